// File: rtl/spdif_pulse_classifier.sv
// S/PDIF front end: synchronises and glitch-filters the raw line, measures the
// width between accepted edges and classifies each as a 1/2/3-UI pulse or an error.
module spdif_pulse_classifier #(
  parameter int unsigned CNT_W    = 5,
  parameter int unsigned FILT_LEN = 2,
  parameter int unsigned ZERO_MIN = 3,
  parameter int unsigned ZERO_MAX = 7,
  parameter int unsigned ONE_MIN  = 9,
  parameter int unsigned ONE_MAX  = 13,
  parameter int unsigned HEAD_MIN = 15,
  parameter int unsigned HEAD_MAX = 19,
  parameter int unsigned LOCK_N   = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_ena,
  input  logic             i_spdif,
  output logic             o_level,
  output logic             o_edge,
  output logic             o_zero,
  output logic             o_one,
  output logic             o_head,
  output logic             o_err,
  output logic             o_valid,
  output logic [CNT_W-1:0] o_width,
  output logic             o_lock
);

  if (!(ZERO_MIN <= ZERO_MAX && ZERO_MAX < ONE_MIN && ONE_MIN <= ONE_MAX &&
        ONE_MAX < HEAD_MIN && HEAD_MIN <= HEAD_MAX &&
        HEAD_MAX < ((1 << CNT_W) - 1) && FILT_LEN >= 1)) begin : g_param_check
    $error("spdif_pulse_classifier: inconsistent width windows or FILT_LEN");
  end

  localparam int unsigned FILT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int unsigned LOCK_W = $clog2(LOCK_N + 1);

  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILT_LEN - 1);
  localparam logic [FILT_W-1:0] FILT_ONE  = FILT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  CNT_PRE   = {{(CNT_W-1){1'b1}}, 1'b0};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  W_ZMIN    = CNT_W'(ZERO_MIN);
  localparam logic [CNT_W-1:0]  W_ZMAX    = CNT_W'(ZERO_MAX);
  localparam logic [CNT_W-1:0]  W_OMIN    = CNT_W'(ONE_MIN);
  localparam logic [CNT_W-1:0]  W_OMAX    = CNT_W'(ONE_MAX);
  localparam logic [CNT_W-1:0]  W_HMIN    = CNT_W'(HEAD_MIN);
  localparam logic [CNT_W-1:0]  W_HMAX    = CNT_W'(HEAD_MAX);
  localparam logic [LOCK_W-1:0] LOCK_FULL = LOCK_W'(LOCK_N);
  localparam logic [LOCK_W-1:0] LOCK_ONE  = LOCK_W'(1);

  logic              sync1_q, sync1_d, sync2_q, sync2_d;
  logic              level_q, level_d;
  logic [FILT_W-1:0] filt_q, filt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              first_q, first_d;
  logic              edge_q, edge_d;
  logic              zero_q, zero_d, one_q, one_d, head_q, head_d;
  logic              err_q, err_d, valid_q, valid_d;
  logic [CNT_W-1:0]  width_q, width_d;
  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
  logic              lock_q, lock_d;
  logic              edge_acc;
  logic              in_zero, in_one, in_head;

  assign in_zero = (cnt_q >= W_ZMIN) && (cnt_q <= W_ZMAX);
  assign in_one  = (cnt_q >= W_OMIN) && (cnt_q <= W_OMAX);
  assign in_head = (cnt_q >= W_HMIN) && (cnt_q <= W_HMAX);

  always_comb begin
    sync1_d    = i_spdif;
    sync2_d    = sync1_q;
    level_d    = level_q;
    filt_d     = filt_q;
    cnt_d      = cnt_q;
    first_d    = first_q;
    width_d    = width_q;
    lock_cnt_d = lock_cnt_q;
    edge_acc   = 1'b0;
    edge_d     = 1'b0;
    zero_d     = 1'b0;
    one_d      = 1'b0;
    head_d     = 1'b0;
    err_d      = 1'b0;

    if (i_ena) begin
      if (sync2_q == level_q) begin
        filt_d = '0;
      end else if (filt_q == FILT_LAST) begin
        filt_d   = '0;
        level_d  = ~level_q;
        edge_acc = 1'b1;
      end else begin
        filt_d = filt_q + FILT_ONE;
      end

      if (edge_acc) begin
        cnt_d  = CNT_ONE;
        edge_d = 1'b1;
        if (first_q) begin
          first_d = 1'b0;
        end else begin
          width_d = cnt_q;
          zero_d  = in_zero;
          one_d   = in_one;
          head_d  = in_head;
          err_d   = !(in_zero || in_one || in_head);
        end
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_ONE;
        // Timeout fires only on the step into saturation, so it pulses once.
        if (cnt_q == CNT_PRE) begin
          err_d   = 1'b1;
          first_d = 1'b1;
        end
      end

      if (err_d) begin
        lock_cnt_d = '0;
      end else if ((zero_d || one_d || head_d) && lock_cnt_q != LOCK_FULL) begin
        lock_cnt_d = lock_cnt_q + LOCK_ONE;
      end
    end

    valid_d = zero_d | one_d | head_d | err_d;
    // Lock derives from the next count so it drops in the same cycle as o_err.
    lock_d  = (lock_cnt_d == LOCK_FULL);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      level_q    <= 1'b0;
      filt_q     <= '0;
      cnt_q      <= '0;
      first_q    <= 1'b1;
      edge_q     <= 1'b0;
      zero_q     <= 1'b0;
      one_q      <= 1'b0;
      head_q     <= 1'b0;
      err_q      <= 1'b0;
      valid_q    <= 1'b0;
      width_q    <= '0;
      lock_cnt_q <= '0;
      lock_q     <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      level_q    <= level_d;
      filt_q     <= filt_d;
      cnt_q      <= cnt_d;
      first_q    <= first_d;
      edge_q     <= edge_d;
      zero_q     <= zero_d;
      one_q      <= one_d;
      head_q     <= head_d;
      err_q      <= err_d;
      valid_q    <= valid_d;
      width_q    <= width_d;
      lock_cnt_q <= lock_cnt_d;
      lock_q     <= lock_d;
    end
  end

  assign o_level = level_q;
  assign o_edge  = edge_q;
  assign o_zero  = zero_q;
  assign o_one   = one_q;
  assign o_head  = head_q;
  assign o_err   = err_q;
  assign o_valid = valid_q;
  assign o_width = width_q;
  assign o_lock  = lock_q;

endmodule

// File: tb/tb_spdif_pulse_classifier.sv
// Scoreboard bench: each line transition queues its expected event, a monitor
// pops and compares whenever the classifier emits o_edge or o_valid.
module tb_spdif_pulse_classifier;

  typedef enum logic [2:0] {K_E, K_Z, K_O, K_H, K_R, K_TO} kind_e;

  typedef struct {
    logic       e, z, o, h, r;
    logic [4:0] w;
    bit         chkw;
    logic       l;
  } exp_t;

  logic       i_clk = 1'b0;
  logic       i_rst_n, i_ena, i_spdif;
  logic       o_level, o_edge, o_zero, o_one, o_head, o_err, o_valid, o_lock;
  logic [4:0] o_width;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  exp_t cur;
  bit   half = 1'b0;

  always #5 i_clk = ~i_clk;

  spdif_pulse_classifier #(
    .CNT_W(5), .FILT_LEN(2), .ZERO_MIN(3), .ZERO_MAX(7), .ONE_MIN(9),
    .ONE_MAX(13), .HEAD_MIN(15), .HEAD_MAX(19), .LOCK_N(8)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ena(i_ena), .i_spdif(i_spdif),
    .o_level(o_level), .o_edge(o_edge), .o_zero(o_zero), .o_one(o_one),
    .o_head(o_head), .o_err(o_err), .o_valid(o_valid), .o_width(o_width),
    .o_lock(o_lock)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input kind_e k, input int w, input logic l);
    exp_t x;
    x.e    = (k != K_TO);
    x.z    = (k == K_Z);
    x.o    = (k == K_O);
    x.h    = (k == K_H);
    x.r    = (k == K_R) || (k == K_TO);
    x.w    = 5'(w);
    x.chkw = (k != K_E) && (k != K_TO);
    x.l    = l;
    return x;
  endfunction

  task automatic hold(input int n);
    repeat (n) begin
      @(negedge i_clk);
      if (half) i_ena = ~i_ena;
    end
  endtask

  task automatic tog(input kind_e k, input int w, input logic l, input int n);
    sb.push_back(mk(k, w, l));
    i_spdif = ~i_spdif;
    hold(n);
  endtask

  task automatic push_to(input logic l);
    sb.push_back(mk(K_TO, 0, l));
  endtask

  always @(negedge i_clk) begin
    if (i_rst_n === 1'b1 && (o_edge === 1'b1 || o_valid === 1'b1)) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_event: edge=%b valid=%b width=%0d at %0t",
                 o_edge, o_valid, o_width, $time);
      end else begin
        cur = sb.pop_front();
        check("edge",  32'(o_edge),  32'(cur.e));
        check("zero",  32'(o_zero),  32'(cur.z));
        check("one",   32'(o_one),   32'(cur.o));
        check("head",  32'(o_head),  32'(cur.h));
        check("err",   32'(o_err),   32'(cur.r));
        check("valid", 32'(o_valid), 32'(cur.z | cur.o | cur.h | cur.r));
        check("lock",  32'(o_lock),  32'(cur.l));
        if (cur.chkw) check("width", 32'(o_width), 32'(cur.w));
      end
    end
  end

  initial begin
    i_rst_n = 1'b0;
    i_ena   = 1'b0;
    i_spdif = 1'b0;
    #1;
    check("rst_level", 32'(o_level), 0);
    check("rst_edge",  32'(o_edge),  0);
    check("rst_zero",  32'(o_zero),  0);
    check("rst_one",   32'(o_one),   0);
    check("rst_head",  32'(o_head),  0);
    check("rst_err",   32'(o_err),   0);
    check("rst_valid", 32'(o_valid), 0);
    check("rst_width", 32'(o_width), 0);
    check("rst_lock",  32'(o_lock),  0);
    hold(3);
    i_rst_n = 1'b1;
    i_ena   = 1'b1;
    hold(3);

    // 5-clk toggles: first edge unclassified, lock on the 8th zero
    tog(K_E, 0, 1'b0, 5);
    for (int i = 1; i <= 11; i++) tog(K_Z, 5, (i >= 8), 5);

    // 11-clk high run with a 1-clk low glitch at clk 5
    tog(K_Z, 5, 1'b1, 5);
    i_spdif = 1'b0;
    hold(1);
    i_spdif = 1'b1;
    hold(5);
    tog(K_O, 11, 1'b1, 5);

    // 8-clk pulse breaks lock; eight zeros to relock, then static timeout
    tog(K_Z, 5, 1'b1, 8);
    tog(K_R, 8, 1'b0, 5);
    for (int i = 1; i <= 8; i++) tog(K_Z, 5, (i == 8), (i == 8) ? 0 : 5);
    push_to(1'b0);
    hold(40);
    tog(K_E, 0, 1'b0, 5);
    tog(K_Z, 5, 1'b0, 0);
    push_to(1'b0);
    hold(40);

    // i_ena every other clk, 10-clk runs measure as 5
    half = 1'b1;
    tog(K_E, 0, 1'b0, 10);
    tog(K_Z, 5, 1'b0, 10);
    tog(K_Z, 5, 1'b0, 10);
    tog(K_Z, 5, 1'b0, 0);
    push_to(1'b0);
    hold(80);
    half  = 1'b0;
    i_ena = 1'b1;

    // 17-clk preamble, then relock before the mid-stream reset
    tog(K_E, 0, 1'b0, 5);
    tog(K_Z, 5, 1'b0, 17);
    tog(K_H, 17, 1'b0, 5);
    for (int i = 1; i <= 8; i++) tog(K_Z, 5, (i >= 6), 5);
    check("pre_rst_lock",  32'(o_lock),  1);
    check("pre_rst_level", 32'(o_level), 1);
    hold(2);
    #2 i_rst_n = 1'b0;
    #1;
    check("mid_rst_level", 32'(o_level), 0);
    check("mid_rst_lock",  32'(o_lock),  0);
    check("mid_rst_width", 32'(o_width), 0);
    check("mid_rst_valid", 32'(o_valid), 0);
    check("mid_rst_edge",  32'(o_edge),  0);
    i_spdif = 1'b0;
    @(negedge i_clk);
    hold(2);
    i_rst_n = 1'b1;
    hold(5);
    tog(K_E, 0, 1'b0, 5);
    tog(K_Z, 5, 1'b0, 5);

    for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge i_clk);
    check("queue_drained", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spdif_pulse_classifier.md
SPDIF_PULSE_CLASSIFIER -- requirements
Module: spdif_pulse_classifier

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- CNT_W, 5, width counter and o_width bits.
- FILT_LEN, 2, consecutive differing samples needed to accept an edge (1 = no filtering).
- ZERO_MIN / ZERO_MAX, 3 / 7, inclusive width window for a 1-UI pulse.
- ONE_MIN / ONE_MAX, 9 / 13, inclusive width window for a 2-UI pulse.
- HEAD_MIN / HEAD_MAX, 15 / 19, inclusive width window for a 3-UI preamble pulse.
- LOCK_N, 8, consecutive good classifications required for lock.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- i_clk, in, 1, clock.
- i_rst_n, in, 1, asynchronous active-low reset.
- i_ena, in, 1, sample strobe.
- i_spdif, in, 1, raw asynchronous S/PDIF line.
- o_level, out, 1, filtered line level.
- o_edge, out, 1, pulse on every accepted edge.
- o_zero, out, 1, 1-UI pulse classified.
- o_one, out, 1, 2-UI pulse classified.
- o_head, out, 1, 3-UI pulse classified.
- o_err, out, 1, width out of window or timeout.
- o_valid, out, 1, o_zero | o_one | o_head | o_err.
- o_width, out, CNT_W, last measured width.
- o_lock, out, 1, stream locked.
REQ-003 Reset SHALL be i_rst_n, asynchronous, active-low; clock SHALL be i_clk; all state on rising i_clk.
REQ-004 Windows SHALL satisfy ZERO_MIN<=ZERO_MAX<ONE_MIN<=ONE_MAX<HEAD_MIN<=HEAD_MAX<2^CNT_W-1 and FILT_LEN>=1; violation SHALL be an elaboration error.

Function
REQ-005 i_spdif SHALL pass a 2-FF synchronizer clocked every i_clk cycle, independent of i_ena.
REQ-006 The glitch filter SHALL advance only on i_ena=1 cycles, as follows.
- filt_cnt increments while sync != o_level.
- filt_cnt clears when sync == o_level.
- On reaching FILT_LEN, o_level toggles, an edge is accepted and filt_cnt clears.
REQ-007 Width counter cnt SHALL advance only on i_ena=1 cycles, as follows.
- Loads 1 on an accepted-edge sample.
- Otherwise increments, saturating at 2^CNT_W-1.
- Width W at an edge is the cnt value before the load.
REQ-008 A first-edge flag SHALL be set by reset and by timeout; an edge with the flag set SHALL clear it, pulse o_edge, and SHALL NOT classify.
REQ-009 Otherwise each accepted edge SHALL register o_width=W and pulse exactly one of the following.
- o_zero if W is in the ZERO window.
- o_one if W is in the ONE window.
- o_head if W is in the HEAD window.
- o_err otherwise.
REQ-010 Timeout: when cnt reaches 2^CNT_W-1 with no edge, o_err SHALL pulse exactly once and the first-edge flag SHALL be set.
REQ-011 o_edge, o_zero, o_one, o_head, o_err and o_valid SHALL be one-i_clk-cycle pulses, asserted the cycle after the deciding i_ena sample, and SHALL deassert on the next cycle regardless of i_ena.
REQ-012 Latency from an i_spdif transition to the classification pulse SHALL be 2 sync cycles + FILT_LEN enabled samples + 1 cycle.
REQ-013 Lock counter lock_cnt SHALL behave as follows.
- Increments, saturating at LOCK_N, on each o_zero/o_one/o_head.
- Clears on o_err.
- o_lock = (lock_cnt == LOCK_N), registered.
- o_lock falls in the same cycle that o_err rises.
REQ-014 With i_ena=0, filter, counter, lock state and o_level SHALL hold.

Reset
REQ-015 Reset SHALL immediately clear the following, with no i_clk required.
- All outputs, including o_width and o_level, to 0.
- Sync FFs, filt_cnt, cnt and lock_cnt to 0.
- The first-edge flag to 1.
REQ-016 Reset mid-stream SHALL discard any partial width; the first edge after release SHALL NOT classify.

Verification
REQ-017 i_ena=1, line toggles every 5 clks -> o_edge per edge, o_zero per edge from the 2nd edge, o_width=5, o_lock=1 on the 8th o_zero.
REQ-018 High run of 11 clks containing a 1-clk low glitch at clk 5 -> no edge mid-run, next edge gives o_one, o_width=11.
REQ-019 After lock, one 8-clk pulse -> o_err with o_width=8, o_lock 1->0 in the same cycle, 8 further o_zero needed to relock.
REQ-020 Line static for 40 clks -> single o_err at cnt=31, o_lock=0; next edge gives o_edge only, the following 5-clk pulse gives o_zero.
REQ-021 i_ena every other clk, line toggling every 10 clks -> o_width=5, o_zero per edge; 17-clk run with i_ena=1 -> o_head, o_width=17.
REQ-022 i_rst_n low mid-stream -> all outputs 0 asynchronously; first edge after release gives no classification pulse.
